// File: rtl/shift_word_sequencer.sv
// Serialises a parallel word into the shr/shl/shin control stream of a downstream mfreg.
// Optional echo compare of the mfreg Q feedback: define SHIFT_WORD_SEQUENCER_ECHO_CHECK_EN.
module shift_word_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] din,
   output logic             shr_out,
   output logic             shl_out,
   output logic             shin_out,
   output logic             busy,
   output logic             done,
   input  logic [WIDTH-1:0] q_in,
   output logic             match
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] word_r;
   logic             dir_r;
   logic [CW-1:0]    cnt_r;

   logic [CW-1:0]    cnt_nxt_s;
   logic [CW-1:0]    rev_idx_s;
   logic             last_s;
   logic             nxt_bit_s;
   logic             first_bit_s;

   // Outputs are registered, so the bit for the next shift cycle is selected one cycle early.
   always_comb begin
      cnt_nxt_s = cnt_r + CW'(1);
      rev_idx_s = CW'(WIDTH - 1) - cnt_nxt_s;
      last_s    = (cnt_r == CW'(WIDTH - 1));
      if (dir_r) begin
         nxt_bit_s = word_r[rev_idx_s];
      end else begin
         nxt_bit_s = word_r[cnt_nxt_s];
      end
      if (dir) begin
         first_bit_s = din[WIDTH-1];
      end else begin
         first_bit_s = din[0];
      end
   end

   // Sequencer FSM with registered control outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         word_r   <= {WIDTH{1'b0}};
         dir_r    <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         shr_out  <= 1'b0;
         shl_out  <= 1'b0;
         shin_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state_r  <= SHIFT;
                  word_r   <= din;
                  dir_r    <= dir;
                  cnt_r    <= {CW{1'b0}};
                  shr_out  <= ~dir;
                  shl_out  <= dir;
                  shin_out <= first_bit_s;
                  busy     <= 1'b1;
               end else begin
                  shr_out  <= 1'b0;
                  shl_out  <= 1'b0;
                  shin_out <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            SHIFT: begin
               if (last_s) begin
                  state_r  <= DONE;
                  shr_out  <= 1'b0;
                  shl_out  <= 1'b0;
                  shin_out <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  cnt_r    <= cnt_nxt_s;
                  shin_out <= nxt_bit_s;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               shr_out  <= 1'b0;
               shl_out  <= 1'b0;
               shin_out <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHIFT_WORD_SEQUENCER_ECHO_CHECK_EN
   logic match_r;

   // Q is complete during DONE; the verdict holds until the next accepted start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         match_r <= 1'b0;
      end else if ((state_r == IDLE) && start) begin
         match_r <= 1'b0;
      end else if (state_r == DONE) begin
         match_r <= (q_in == word_r);
      end else begin
         match_r <= match_r;
      end
   end

   assign match = match_r;
`else
   logic unused_q_in_s;
   assign unused_q_in_s = ^q_in;
   assign match         = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_sequencer.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// against a transfer-schedule reference model plus a behavioural downstream mfreg.
module tb_shift_word_sequencer;

   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, dir;
   logic [W-1:0] din, q_in;
   logic         shr_out, shl_out, shin_out, busy, done, match;
   logic [W-1:0] q_mfreg;
   logic         q_zero;

   assign q_in = q_zero ? {W{1'b0}} : q_mfreg;

   shift_word_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .din(din),
      .shr_out(shr_out), .shl_out(shl_out), .shin_out(shin_out),
      .busy(busy), .done(done), .q_in(q_in), .match(match)
   );

   typedef struct packed {
      logic shr;
      logic shl;
      logic shin;
      logic busy;
      logic done;
   } ctl_t;

   typedef struct {
      logic   r;
      logic   s;
      logic   d;
      logic [W-1:0] w;
      ctl_t   e;
   } vec_t;

   ctl_t         sched[$];
   ctl_t         cur_exp;
   logic [W-1:0] word_exp;
   logic         match_exp;
   int           total;
   int           bad;
   int           done_cnt;

   function automatic ctl_t dut_ctl();
      return {shr_out, shl_out, shin_out, busy, done};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an accepted start schedules W shift cycles then one done cycle.
   task automatic model_edge(input logic r, input logic s, input logic d,
                             input logic [W-1:0] w, input logic [W-1:0] qb);
      if (!r) begin
         sched.delete();
         cur_exp   = 5'b00000;
         match_exp = 1'b0;
      end else begin
         if (!cur_exp.busy && !cur_exp.done && s) begin
            for (int i = 0; i < W; i++) begin
               ctl_t e;
               e.shr  = !d;
               e.shl  = d;
               e.shin = d ? w[W-1-i] : w[i];
               e.busy = 1'b1;
               e.done = 1'b0;
               sched.push_back(e);
            end
            sched.push_back(5'b00001);
            word_exp  = w;
            match_exp = 1'b0;
         end
`ifdef SHIFT_WORD_SEQUENCER_ECHO_CHECK_EN
         if (cur_exp.done) match_exp = (qb == word_exp);
`endif
         cur_exp = (sched.size() > 0) ? sched.pop_front() : 5'b00000;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic d, input logic [W-1:0] w);
      ctl_t         seen;
      logic [W-1:0] qb;
      rst   = r;
      start = s;
      dir   = d;
      din   = w;
      seen  = dut_ctl();
      @(posedge clk);
      qb = q_in;
      #1;
      if (seen.shr === 1'b1)      q_mfreg = {seen.shin, q_mfreg[W-1:1]};
      else if (seen.shl === 1'b1) q_mfreg = {q_mfreg[W-2:0], seen.shin};
      model_edge(r, s, d, w, qb);
      @(negedge clk);
      check("ctl", {11'd0, dut_ctl()}, {11'd0, cur_exp});
      check("match", {15'd0, match}, {15'd0, match_exp});
      if (cur_exp.done) check("mfreg_q", {12'd0, q_mfreg}, {12'd0, word_exp});
      if (done === 1'b1) done_cnt++;
   endtask

   vec_t         tbl [9];
   logic [W-1:0] bits;

   initial begin
      total     = 0;
      bad       = 0;
      done_cnt  = 0;
      rst       = 1'b0;
      start     = 1'b0;
      dir       = 1'b0;
      din       = 4'b0000;
      q_mfreg   = 4'b0000;
      q_zero    = 1'b0;
      cur_exp   = 5'b00000;
      word_exp  = 4'b0000;
      match_exp = 1'b0;

      // rows: rst, start, dir, din, expected {shr,shl,shin,busy,done} after the edge
      tbl[0] = '{1'b0, 1'b1, 1'b0, 4'b1111, 5'b00000};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 4'b0000, 5'b00000};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b0111, 5'b10110};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 4'b1000, 5'b10110};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 4'b0000, 5'b10110};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 4'b0000, 5'b10010};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 4'b1111, 5'b00001};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000};

      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].w);
         check("vec", {11'd0, dut_ctl()}, {11'd0, tbl[i].e});
      end
      check("right_q", {12'd0, q_mfreg}, {12'd0, 4'b0111});

      // left shift: MSB first
      done_cnt = 0;
      bits     = 4'b0000;
      step(1'b1, 1'b1, 1'b1, 4'b1110);
      for (int i = 0; i < 4; i++) begin
         check("left_shl", {14'd0, shl_out, shr_out}, {14'd0, 1'b1, 1'b0});
         bits = {bits[W-2:0], shin_out};
         step(1'b1, 1'b0, 1'b0, 4'b0000);
      end
      check("left_bits", {12'd0, bits}, {12'd0, 4'b1110});
      check("left_done", {15'd0, done}, 16'd1);
      check("left_q", {12'd0, q_mfreg}, {12'd0, 4'b1110});
      step(1'b1, 1'b0, 1'b0, 4'b0000);

      // start while busy is ignored
      done_cnt = 0;
      step(1'b1, 1'b1, 1'b0, 4'b1010);
      step(1'b1, 1'b0, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 1'b1, 4'b0101);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4'b0000);
      check("busy_done_cnt", 16'(done_cnt), 16'd1);
      check("busy_q", {12'd0, q_mfreg}, {12'd0, 4'b1010});

      // reset after two shift cycles, then a clean transfer
      done_cnt = 0;
      step(1'b1, 1'b1, 1'b0, 4'b0110);
      step(1'b1, 1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      check("rst_mid", {11'd0, dut_ctl()}, 16'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'b0000);
      check("rst_no_done", 16'(done_cnt), 16'd0);
      step(1'b1, 1'b1, 1'b0, 4'b1001);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'b0000);
      check("rst_then_done", 16'(done_cnt), 16'd1);
      check("rst_then_q", {12'd0, q_mfreg}, {12'd0, 4'b1001});

      // forced-zero feedback, then a fresh start
      q_zero = 1'b1;
      step(1'b1, 1'b1, 1'b0, 4'b1010);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4'b0000);
      check("echo_bad", {15'd0, match}, 16'd0);
      q_zero = 1'b0;
      step(1'b1, 1'b1, 1'b1, 4'b0011);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 4'b0000);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         q_zero = ($urandom_range(0, 7) == 0);
         step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
              1'($urandom), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_word_sequencer.md
Name: shift_word_sequencer

Overview:
- Transmit-side companion to the multifunction register (mfreg).
- Accepts a parallel word and generates the shr/shl/shin control stream that shifts the word serially into a downstream mfreg.
- After WIDTH shift cycles, the mfreg Q equals the word.
- Replaces hand-written shin sequences in benches; reusable as a serial link driver between register blocks.

Parameters:
- WIDTH, 4, word width; equals the downstream mfreg width; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising edge of clk).
- start  input  1  request to send din; sampled in IDLE only.
- dir  input  1  0 = right shift (drive shr), 1 = left shift (drive shl); latched with din.
- din  input  WIDTH  word to deliver; latched on accepted start.
- shr_out  output  1  right-shift enable to the mfreg shr input.
- shl_out  output  1  left-shift enable to the mfreg shl input.
- shin_out  output  1  serial bit to the mfreg shin input.
- busy  output  1  high from the cycle after accept through the last shift cycle.
- done  output  1  one-cycle pulse after the last shift cycle.
- q_in  input  WIDTH  mfreg Q feedback; used only with ECHO_CHECK_EN, otherwise ignored.
- match  output  1  ECHO_CHECK_EN only; tied 0 when the macro is absent.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge):
  - state=IDLE; shr_out, shl_out, shin_out, busy, done and match = 0.
  - Latched word, latched dir and counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches din into word_r, latches dir into dir_r, clears cnt, and moves to SHIFT.
  - The first shift cycle is the cycle immediately after start is sampled. No shift outputs are asserted in the accept cycle.
- SHIFT (exactly WIDTH cycles, cnt = 0..WIDTH-1):
  - busy=1.
  - Exactly one of shr_out/shl_out is high, selected by dir_r. Both are never high together.
  - dir_r=0: shin_out = word_r[cnt]. LSB is sent first, so after WIDTH right shifts it sits in Q[0].
  - dir_r=1: shin_out = word_r[WIDTH-1-cnt]. MSB is sent first, so after WIDTH left shifts it sits in Q[WIDTH-1].
  - The downstream register samples at the edge that ends each SHIFT cycle.
  - After cnt = WIDTH-1, go to DONE.
- DONE (1 cycle):
  - busy=0, done=1, shr_out=shl_out=0, shin_out=0. Then return to IDLE.
  - A start seen in DONE is ignored. Earliest re-accept is the cycle after DONE, in IDLE.
- start while busy or done: ignored. The in-flight word is not corrupted. Changes to din/dir mid-transfer have no effect.
- Reset mid-SHIFT: the next cycle is IDLE with all control outputs 0. The partial word stays in the mfreg; no done pulse is produced.
- In IDLE and DONE, shr_out=shl_out=0 so the downstream register holds its value.
- Total latency from accepted start to done high: WIDTH+1 cycles.
- Counter width is $clog2(WIDTH). The counter does not wrap within a transfer.

Optional Feature:
- Macro: SHIFT_WORD_SEQUENCER_ECHO_CHECK_EN.
- Defined:
  - In the DONE cycle, match is registered to (q_in == word_r) and held until the next accepted start or reset. Both clear it to 0.
  - q_in is sampled at the DONE-state edge, when the mfreg Q has absorbed the final bit.
- Undefined:
  - match is a constant 0. q_in is unused, with no logic and no lint-relevant loads beyond the port.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> all outputs 0, no shifting; release rst -> IDLE.
- Right shift: din=4'b0111, dir=0, start for 1 cycle.
  - shr_out=1 for 4 cycles; shin_out sequence 1,1,1,0; shl_out stays 0.
  - done pulses on cycle 5; attached mfreg Q=4'b0111.
- Left shift: din=4'b1110, dir=1.
  - shl_out=1 for 4 cycles; shin_out sequence 1,1,1,0.
  - done on cycle 5; Q=4'b1110; with ECHO_CHECK_EN, match=1.
- Busy ignore: start with din=4'b1010, then pulse start with din=4'b0101 during SHIFT -> only 1010 delivered; exactly one done pulse.
- Reset mid-transfer: assert rst=0 after 2 shift cycles -> next cycle shr_out=0, busy=0, no done; a subsequent start of 4'b1001 completes normally.
- Echo mismatch (ECHO_CHECK_EN): force q_in=4'b0000 while sending 4'b1010 -> match=0 at DONE; a new start clears match.
